// File: rtl/flog_bf16_top.sv
// bfloat16 log2 unit: IDLE/CALC/DONE handshake around a 3-stage fixed-point datapath.
// The datapath uses the integer exponent, a log2(1.f) ROM, leading-one normalisation and RNE rounding.
package flog_pkg;
    localparam int EXP_WIDTH   = 8;
    localparam int FRACT_WIDTH = 7;
    localparam int S_WIDTH     = 1;
    localparam int LUT_FRAC    = 16;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [S_WIDTH-1:0]     s;
        logic [EXP_WIDTH-1:0]   e;
        logic [FRACT_WIDTH-1:0] f;
    } bf16_t;
endpackage

module flog_bf16_top
    import flog_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [S_WIDTH-1:0]     sign,
    input  logic [EXP_WIDTH-1:0]   exponent,
    input  logic [FRACT_WIDTH-1:0] fractional,
    input  logic                   valid_i,
    output logic [S_WIDTH-1:0]     s_res_o,
    output logic [EXP_WIDTH-1:0]   e_res_o,
    output logic [FRACT_WIDTH-1:0] f_res_o,
    output logic                   valid_o
);
    localparam int INT_W = EXP_WIDTH + 1;
    localparam int SUM_W = INT_W + LUT_FRAC;
    localparam int MAG_W = SUM_W - 1;
    localparam int NRM_W = MAG_W - 1;
    localparam int LZ_W  = $clog2(MAG_W);
    localparam int ROM_N = 1 << FRACT_WIDTH;
    localparam logic [EXP_WIDTH-1:0]   EXP_MAX = '1;
    localparam logic [EXP_WIDTH-1:0]   BIAS    = EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic [FRACT_WIDTH-1:0] QNAN_F  = {1'b1, {(FRACT_WIDTH - 1){1'b0}}};

    // Elaboration-time log2 by repeated squaring in Q2.60, 8 guard bits, then rounded.
    function automatic logic [LUT_FRAC-1:0] lut_entry(input int idx);
        logic [127:0]          x;
        logic [LUT_FRAC+7:0]   r;
        x = 128'((1 << FRACT_WIDTH) + idx) << (60 - FRACT_WIDTH);
        r = '0;
        for (int k = 0; k < LUT_FRAC + 8; k++) begin
            x = (x * x) >> 60;
            r = r << 1;
            if (x >= (128'd2 << 60)) begin
                x    = x >> 1;
                r[0] = 1'b1;
            end
        end
        lut_entry = LUT_FRAC'((r + (LUT_FRAC + 8)'(128)) >> 8);
    endfunction

    // NOTE: the ROM is constant wiring, not storage, so it has no reset or write port.
    logic [LUT_FRAC-1:0] rom [ROM_N];
    for (genvar g = 0; g < ROM_N; g++) begin : g_rom
        localparam logic [LUT_FRAC-1:0] ENTRY = lut_entry(g);
        assign rom[g] = ENTRY;
    end

    state_t                 state;
    logic [1:0]             cnt;
    logic [S_WIDTH-1:0]     op_s;
    logic [EXP_WIDTH-1:0]   op_e;
    logic [FRACT_WIDTH-1:0] op_f;
    logic                   spec_q, neg_q;
    bf16_t                  spec_val_q, res_q;
    logic [MAG_W-1:0]       mag_q;
    logic [NRM_W-1:0]       nrm_q;
    logic [LZ_W-1:0]        lead_q;

    logic [INT_W-1:0]       int_a;
    logic [SUM_W-1:0]       sum_a;
    logic [MAG_W-1:0]       mag_a;
    logic                   neg_a, spec_a;
    bf16_t                  spec_val_a;
    logic [LZ_W-1:0]        lead_b;
    logic [FRACT_WIDTH:0]   mant_c;
    logic                   rnd_c;
    bf16_t                  norm_c;

    always_comb begin
        int_a = INT_W'(op_e) - INT_W'(BIAS);
        sum_a = {int_a, {LUT_FRAC{1'b0}}} + SUM_W'(rom[op_f]);
        neg_a = sum_a[SUM_W-1];
        mag_a = neg_a ? MAG_W'(-sum_a) : MAG_W'(sum_a);

        spec_a       = 1'b1;
        spec_val_a.s = '0;
        spec_val_a.e = EXP_MAX;
        spec_val_a.f = QNAN_F;
        if (op_e == EXP_MAX && op_f != '0) begin
            spec_val_a.f = QNAN_F;
        end else if (op_e == '0) begin
            spec_val_a.s = '1;
            spec_val_a.f = '0;
        end else if (op_s != '0) begin
            spec_val_a.f = QNAN_F;
        end else if (op_e == EXP_MAX) begin
            spec_val_a.f = '0;
        end else if (op_e == BIAS && op_f == '0) begin
            spec_val_a.e = '0;
            spec_val_a.f = '0;
        end else begin
            spec_a = 1'b0;
        end
    end

    always_comb begin
        lead_b = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (mag_q[i]) lead_b = LZ_W'(i);
        end
    end

    // Mantissa sits just below the implicit one at nrm_q[NRM_W]; guard and sticky follow it.
    always_comb begin
        rnd_c    = nrm_q[NRM_W-1-FRACT_WIDTH]
                   & ((|nrm_q[NRM_W-2-FRACT_WIDTH:0]) | nrm_q[NRM_W-FRACT_WIDTH]);
        mant_c   = {1'b0, nrm_q[NRM_W-1 -: FRACT_WIDTH]} + (FRACT_WIDTH + 1)'(rnd_c);
        norm_c.s = S_WIDTH'(neg_q);
        norm_c.e = BIAS - EXP_WIDTH'(LUT_FRAC) + EXP_WIDTH'(lead_q)
                   + EXP_WIDTH'(mant_c[FRACT_WIDTH]);
        norm_c.f = mant_c[FRACT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_s       <= '0;
            op_e       <= '0;
            op_f       <= '0;
            spec_q     <= 1'b0;
            neg_q      <= 1'b0;
            spec_val_q <= '0;
            res_q      <= '0;
            mag_q      <= '0;
            nrm_q      <= '0;
            lead_q     <= '0;
            s_res_o    <= '0;
            e_res_o    <= '0;
            f_res_o    <= '0;
            valid_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    op_s  <= sign;
                    op_e  <= exponent;
                    op_f  <= fractional;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    cnt <= cnt + 2'd1;
                    case (cnt)
                        2'd0: begin
                            spec_q     <= spec_a;
                            spec_val_q <= spec_val_a;
                            neg_q      <= neg_a;
                            mag_q      <= mag_a;
                        end
                        2'd1: begin
                            nrm_q  <= NRM_W'(mag_q << (LZ_W'(MAG_W - 1) - lead_b));
                            lead_q <= lead_b;
                        end
                        2'd2: res_q <= spec_q ? spec_val_q : norm_c;
                        default: begin
                            s_res_o <= res_q.s;
                            e_res_o <= res_q.e;
                            f_res_o <= res_q.f;
                            valid_o <= 1'b1;
                            state   <= DONE;
                        end
                    endcase
                end
                DONE: if (!valid_i) begin
                    valid_o <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flog_bf16_top.sv
// Directed and randomised checks of flog_bf16_top: results, specials, latency, handshake, reset abort.
module tb_flog_bf16_top;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sign = 1'b0;
    logic [7:0] exponent = '0;
    logic [6:0] fractional = '0;
    logic       valid_i = 1'b0;
    logic       s_res_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;
    logic       valid_o;

    int compared = 0;
    int mismatched = 0;

    flog_bf16_top dut (
        .clk(clk), .rst(rst), .sign(sign), .exponent(exponent), .fractional(fractional),
        .valid_i(valid_i), .s_res_o(s_res_o), .e_res_o(e_res_o), .f_res_o(f_res_o),
        .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) repeat (n) r = r * 2.0;
        else repeat (-n) r = r / 2.0;
        return r;
    endfunction

    // Presents an operand, waits (bounded) for valid_o; leaves valid_i high unless dropped early.
    task automatic run_op(input logic s, input logic [7:0] e, input logic [6:0] f,
                          input bit drop_early, output logic [15:0] res, output int lat);
        @(negedge clk);
        sign = s; exponent = e; fractional = f; valid_i = 1'b1;
        @(posedge clk);
        if (drop_early) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid_o) break;
        end
        res = {s_res_o, e_res_o, f_res_o};
    endtask

    task automatic release_op(input string tag);
        @(negedge clk);
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, 32'(valid_o), 32'd0);
    endtask

    task automatic directed(input string tag, input logic s, input logic [7:0] e,
                            input logic [6:0] f, input logic [15:0] exp_res);
        logic [15:0] res;
        int          lat;
        run_op(s, e, f, 1'b0, res, lat);
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " result"}, 32'(res), 32'(exp_res));
        release_op({tag, " valid_o drop"});
    endtask

    initial begin
        logic [15:0] res;
        int          lat;
        int          e_r, f_r, re, rf;
        real         ref_v, dv, ulp;
        logic [15:0] exp_res;
        bit          is_spec;

        #8;
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset result", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 124.4178 rounds up to 124.5; then hold valid_i one extra cycle.
        run_op(1'b0, 8'hFB, 7'h2B, 1'b0, res, lat);
        chk("big latency", 32'(lat), 32'd4);
        chk("big result", 32'(res), 32'h42F9);
        @(posedge clk);
        #1;
        chk("hold valid_o", 32'(valid_o), 32'd1);
        chk("hold result", 32'({s_res_o, e_res_o, f_res_o}), 32'h42F9);
        release_op("hold valid_o drop");
        chk("result held after done", 32'({s_res_o, e_res_o, f_res_o}), 32'h42F9);

        directed("x8F_7A", 1'b0, 8'h8F, 7'h7A, 16'h4188);
        directed("two", 1'b0, 8'h80, 7'h00, 16'h3F80);
        directed("half", 1'b0, 8'h7E, 7'h00, 16'hBF80);
        directed("one", 1'b0, 8'h7F, 7'h00, 16'h0000);
        directed("max normal", 1'b0, 8'hFE, 7'h7F, 16'h4300);
        directed("min normal", 1'b0, 8'h01, 7'h00, 16'hC2FC);
        directed("pos inf", 1'b0, 8'hFF, 7'h00, 16'h7F80);
        directed("pos zero", 1'b0, 8'h00, 7'h00, 16'hFF80);
        directed("qnan in", 1'b0, 8'hFF, 7'h40, 16'h7FC0);
        directed("snan in", 1'b0, 8'hFF, 7'h3F, 16'h7FC0);
        directed("negative", 1'b1, 8'hAA, 7'h50, 16'h7FC0);
        directed("neg denormal", 1'b1, 8'h00, 7'h05, 16'hFF80);
        directed("neg inf", 1'b1, 8'hFF, 7'h00, 16'h7FC0);
        directed("neg nan", 1'b1, 8'hFF, 7'h01, 16'h7FC0);

        // valid_i dropped during CALC must not abort the operation.
        run_op(1'b0, 8'h81, 7'h00, 1'b1, res, lat);
        chk("early drop latency", 32'(lat), 32'd4);
        chk("early drop result", 32'(res), 32'h4000);
        @(posedge clk);
        #1;
        chk("early drop valid_o fall", 32'(valid_o), 32'd0);

        // Reset two cycles after capture clears outputs at once and yields no result.
        @(negedge clk);
        sign = 1'b0; exponent = 8'h80; fractional = 7'h00; valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort valid_o", 32'(valid_o), 32'd0);
        chk("abort result", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort no result valid", 32'(valid_o), 32'd0);
        chk("abort no result value", 32'({s_res_o, e_res_o, f_res_o}), 32'd0);
        directed("after abort", 1'b0, 8'h80, 7'h00, 16'h3F80);

        for (int n = 0; n < 1000; n++) begin
            e_r = int'($urandom_range(0, 255));
            f_r = int'($urandom_range(0, 127));
            run_op(1'b0, 8'(e_r), 7'(f_r), 1'b0, res, lat);
            chk("rand latency", 32'(lat), 32'd4);
            is_spec = 1'b1;
            exp_res = '0;
            if (e_r == 255 && f_r != 0) exp_res = 16'h7FC0;
            else if (e_r == 0)          exp_res = 16'hFF80;
            else if (e_r == 255)        exp_res = 16'h7F80;
            else if (e_r == 127 && f_r == 0) exp_res = 16'h0000;
            else is_spec = 1'b0;
            if (is_spec) begin
                chk("rand special", 32'(res), 32'(exp_res));
            end else begin
                ref_v = real'(e_r - 127) + $ln(1.0 + real'(f_r) / 128.0) / $ln(2.0);
                re = int'(res[14:7]);
                rf = int'(res[6:0]);
                dv = (1.0 + real'(rf) / 128.0) * pow2(re - 127);
                if (res[15]) dv = -dv;
                ulp = pow2(re - 127 - 7);
                chk("rand within half ulp",
                    32'((dv - ref_v <= 0.5 * ulp + pow2(-16)) && (ref_v - dv <= 0.5 * ulp + pow2(-16))),
                    32'd1);
            end
            release_op("rand valid_o drop");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
